cam_pixel_packer: RTL and testbench



---
 rtl/cam_packer_pkg.sv | 15 +
 rtl/cam_pixel_packer_word_buffer.sv | 73 +++++++
 rtl/cam_pixel_packer.sv | 157 +++++++++++++++
 tb/tb_cam_pixel_packer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_packer_pkg.sv
// Shared frame geometry and FSM state type for the camera pixel packer.
package cam_packer_pkg;

  localparam int H_ACTIVE        = 1280;
  localparam int V_ACTIVE        = 720;
  localparam int PIXELS_PER_WORD = 8;
  localparam int WORDS_PER_FRAME = H_ACTIVE * V_ACTIVE / PIXELS_PER_WORD;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    PACK     = 2'd1,
    ABORT    = 2'd2
  } packer_state_t;

endpackage

// File: rtl/cam_pixel_packer_word_buffer.sv
// axis_word_buffer: 2-entry FIFO of {tlast, data} with registered AXI-Stream outputs.
// Slot 0 always holds the head word, so the output needs no read mux.
module axis_word_buffer #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] push_data_in,
  output logic             can_push_out,
  output logic [WIDTH-1:0] m_data_out,
  output logic             m_valid_out,
  input  logic             m_ready_in
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;
  logic             full;
  logic             pop;
  logic             do_push;

  always_comb begin
    full         = (count_q == 2'(DEPTH));
    pop          = (count_q != 2'd0) && m_ready_in;
    can_push_out = !full || pop;
    do_push      = push_in && can_push_out;
    slot0_d      = slot0_q;
    slot1_d      = slot1_q;
    count_d      = count_q;
    // A simultaneous push and pop keeps the count and shifts the queue forward.
    case ({do_push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          slot0_d = push_data_in;
        end else begin
          slot1_d = push_data_in;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          slot0_d = push_data_in;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign m_data_out  = slot0_q;
  assign m_valid_out = (count_q != 2'd0);

endmodule

// File: rtl/cam_pixel_packer.sv
// Packs 8 RGB565 pixels per 128-bit AXI-Stream word, aborting misaligned frames.
// Optional CAM_PACKER_TEST_PATTERN_EN replaces pixel data with {vcount[4:0], hcount}.
module cam_pixel_packer
  import cam_packer_pkg::*;
#(
  parameter int H_ACTIVE  = cam_packer_pkg::H_ACTIVE,
  parameter int V_ACTIVE  = cam_packer_pkg::V_ACTIVE,
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         pixel_valid_in,
  input  logic [15:0]  pixel_data_in,
  input  logic [10:0]  hcount_in,
  input  logic [9:0]   vcount_in,
  output logic [127:0] write_axis_data,
  output logic         write_axis_valid,
  output logic         write_axis_tlast,
  input  logic         write_axis_ready,
  output logic         overflow_out,
  output logic         resync_out
);

  packer_state_t state_q, state_d;
  logic [2:0]    lane_q, lane_d;
  logic [10:0]   exp_h_q, exp_h_d;
  logic [9:0]    exp_v_q, exp_v_d;
  logic [111:0]  word_q, word_d;
  logic          overflow_q, overflow_d;
  logic          resync_q, resync_d;

  logic [15:0]   pixel;
  logic          pos_match;
  logic          frame_end;
  logic          push;
  logic [128:0]  push_data;
  logic          can_push;
  logic [128:0]  buf_data;

`ifdef CAM_PACKER_TEST_PATTERN_EN
  assign pixel = {vcount_in[4:0], hcount_in};
`else
  assign pixel = pixel_data_in;
`endif

  assign pos_match = (hcount_in == exp_h_q) && (vcount_in == exp_v_q);
  assign frame_end = (exp_h_q == 11'(H_ACTIVE - 1)) && (exp_v_q == 10'(V_ACTIVE - 1));

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    exp_h_d    = exp_h_q;
    exp_v_d    = exp_v_q;
    word_d     = word_q;
    overflow_d = overflow_q;
    resync_d   = 1'b0;
    push       = 1'b0;
    push_data  = '0;
    case (state_q)
      WAIT_SOF: begin
        if (pixel_valid_in && hcount_in == 11'd0 && vcount_in == 10'd0) begin
          word_d[15:0] = pixel;
          lane_d       = 3'd1;
          exp_h_d      = 11'd1;
          exp_v_d      = 10'd0;
          state_d      = PACK;
        end
      end
      PACK: begin
        if (pixel_valid_in) begin
          if (!pos_match) begin
            state_d  = ABORT;
            resync_d = 1'b1;
          end else if (lane_q == 3'(PIXELS_PER_WORD - 1)) begin
            push      = 1'b1;
            push_data = {frame_end, pixel, word_q};
            if (can_push) begin
              lane_d = 3'd0;
              if (frame_end) begin
                state_d = WAIT_SOF;
              end
            end else begin
              overflow_d = 1'b1;
              resync_d   = 1'b1;
              state_d    = ABORT;
            end
          end else begin
            for (int k = 0; k < PIXELS_PER_WORD - 1; k++) begin
              if (lane_q == 3'(k)) begin
                word_d[16*k +: 16] = pixel;
              end
            end
            lane_d = lane_q + 3'd1;
          end
          if (pos_match) begin
            if (exp_h_q == 11'(H_ACTIVE - 1)) begin
              exp_h_d = 11'd0;
              exp_v_d = (exp_v_q == 10'(V_ACTIVE - 1)) ? 10'd0 : exp_v_q + 10'd1;
            end else begin
              exp_h_d = exp_h_q + 11'd1;
            end
          end
        end
      end
      ABORT: begin
        // The terminator (zero data, tlast) realigns the downstream address counter.
        push      = 1'b1;
        push_data = {1'b1, 128'd0};
        if (can_push) begin
          lane_d  = 3'd0;
          state_d = WAIT_SOF;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= WAIT_SOF;
      lane_q     <= 3'd0;
      exp_h_q    <= 11'd0;
      exp_v_q    <= 10'd0;
      word_q     <= '0;
      overflow_q <= 1'b0;
      resync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      exp_h_q    <= exp_h_d;
      exp_v_q    <= exp_v_d;
      word_q     <= word_d;
      overflow_q <= overflow_d;
      resync_q   <= resync_d;
    end
  end

  axis_word_buffer #(
    .WIDTH (129),
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .push_in      (push),
    .push_data_in (push_data),
    .can_push_out (can_push),
    .m_data_out   (buf_data),
    .m_valid_out  (write_axis_valid),
    .m_ready_in   (write_axis_ready)
  );

  assign write_axis_data  = buf_data[127:0];
  assign write_axis_tlast = buf_data[128];
  assign overflow_out     = overflow_q;
  assign resync_out       = resync_q;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Self-checking bench for cam_pixel_packer using a reduced 64x16 frame.
// Vector table for alignment corner cases plus scoreboarded multi-cycle sequences.
module tb_cam_pixel_packer;

  localparam int TH     = 64;
  localparam int TV     = 16;
  localparam int TPIX   = TH * TV;
  localparam int TWORDS = TPIX / 8;

  logic         clk_in;
  logic         rst_in;
  logic         pixel_valid_in;
  logic [15:0]  pixel_data_in;
  logic [10:0]  hcount_in;
  logic [9:0]   vcount_in;
  logic [127:0] write_axis_data;
  logic         write_axis_valid;
  logic         write_axis_tlast;
  logic         write_axis_ready;
  logic         overflow_out;
  logic         resync_out;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } word_t;

  typedef struct {
    logic        valid;
    logic [10:0] h;
    logic [9:0]  v;
    logic        exp_resync;
    logic        exp_term;
  } vec_t;

  word_t        exp_q[$];
  word_t        mon_e;
  vec_t         vecs[17];
  int           checks = 0;
  int           errors = 0;
  int           resync_count = 0;
  int           resync_base;
  int           ready_mode = 1;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic         prev_last;

  cam_pixel_packer #(
    .H_ACTIVE  (TH),
    .V_ACTIVE  (TV),
    .BUF_DEPTH (2)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .pixel_valid_in   (pixel_valid_in),
    .pixel_data_in    (pixel_data_in),
    .hcount_in        (hcount_in),
    .vcount_in        (vcount_in),
    .write_axis_data  (write_axis_data),
    .write_axis_valid (write_axis_valid),
    .write_axis_tlast (write_axis_tlast),
    .write_axis_ready (write_axis_ready),
    .overflow_out     (overflow_out),
    .resync_out       (resync_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [10:0] h, input logic [9:0] vc, input logic [15:0] d);
    pixel_valid_in = v;
    hcount_in      = h;
    vcount_in      = vc;
    pixel_data_in  = d;
    case (ready_mode)
      0:       write_axis_ready = 1'b0;
      1:       write_axis_ready = 1'b1;
      default: write_axis_ready = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [15:0] exp_pixel(input int p);
    logic [10:0] hh;
    logic [9:0]  vv;
    logic [31:0] pp;
    hh = 11'(p % TH);
    vv = 10'(p / TH);
    pp = 32'(p);
`ifdef CAM_PACKER_TEST_PATTERN_EN
    return {vv[4:0], hh};
`else
    if (hh == 11'h7FF && vv == 10'h3FF) return 16'h0;
    return pp[15:0];
`endif
  endfunction

  task automatic push_expected_words(input int first_w, input int n);
    word_t e;
    for (int w = first_w; w < first_w + n; w++) begin
      e.data = '0;
      for (int k = 0; k < 8; k++) e.data[16*k +: 16] = exp_pixel(8 * w + k);
      e.last = (w == TWORDS - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_terminator();
    word_t e;
    e.data = '0;
    e.last = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic drive_pixels(input int first_p, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b1, 11'((first_p + i) % TH), 10'((first_p + i) / TH), 16'(first_p + i));
      repeat (gap) apply_stimulus(1'b0, 11'd0, 10'd0, 16'd0);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      apply_stimulus(1'b0, 11'd0, 10'd0, 16'd0);
      n++;
    end
    check_output(name, 128'(exp_q.size()), 128'd0);
    repeat (4) apply_stimulus(1'b0, 11'd0, 10'd0, 16'd0);
  endtask

  // Output monitor: scoreboard on every handshake, hold check on every stall.
  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_stall <= 1'b0;
    end else begin
      if (resync_out) resync_count++;
      if (prev_stall && write_axis_valid) begin
        check_output("stall_hold_data", write_axis_data, prev_data);
        check_output("stall_hold_tlast", 128'(write_axis_tlast), 128'(prev_last));
      end
      if (write_axis_valid && write_axis_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word actual=%h tlast=%b required=no word", write_axis_data, write_axis_tlast);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("word_data", write_axis_data, mon_e.data);
          check_output("word_tlast", 128'(write_axis_tlast), 128'(mon_e.last));
        end
      end
      prev_stall <= write_axis_valid && !write_axis_ready;
      prev_data  <= write_axis_data;
      prev_last  <= write_axis_tlast;
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 11'd5,    10'd0,  1'b0, 1'b0};
    vecs[1]  = '{1'b0, 11'd0,    10'd0,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, 11'd0,    10'd0,  1'b0, 1'b0};
    vecs[3]  = '{1'b1, 11'd1,    10'd0,  1'b0, 1'b0};
    vecs[4]  = '{1'b0, 11'd9,    10'd9,  1'b0, 1'b0};
    vecs[5]  = '{1'b1, 11'd2,    10'd0,  1'b0, 1'b0};
    vecs[6]  = '{1'b1, 11'd4,    10'd0,  1'b1, 1'b1};
    vecs[7]  = '{1'b1, 11'd0,    10'd0,  1'b0, 1'b0};
    vecs[8]  = '{1'b1, 11'd0,    10'd0,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 11'd0,    10'd0,  1'b1, 1'b1};
    vecs[10] = '{1'b1, 11'd1,    10'd0,  1'b0, 1'b0};
    vecs[11] = '{1'b1, 11'd0,    10'd0,  1'b0, 1'b0};
    vecs[12] = '{1'b1, 11'd2000, 10'd0,  1'b1, 1'b1};
    vecs[13] = '{1'b0, 11'd0,    10'd0,  1'b0, 1'b0};
    vecs[14] = '{1'b1, 11'd0,    10'd0,  1'b0, 1'b0};
    vecs[15] = '{1'b1, 11'd1,    10'd20, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 11'd0,    10'd0,  1'b0, 1'b0};

    rst_in = 1'b1;
    ready_mode = 1;
    repeat (3) apply_stimulus(1'b0, 11'd0, 10'd0, 16'd0);
    check_output("rst_valid", 128'(write_axis_valid), 128'd0);
    check_output("rst_tlast", 128'(write_axis_tlast), 128'd0);
    check_output("rst_data", write_axis_data, 128'd0);
    check_output("rst_overflow", 128'(overflow_out), 128'd0);
    check_output("rst_resync", 128'(resync_out), 128'd0);
    rst_in = 1'b0;
    apply_stimulus(1'b0, 11'd0, 10'd0, 16'd0);

    $display("[TB] alignment vector table");
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].exp_term) push_terminator();
      apply_stimulus(vecs[i].valid, vecs[i].h, vecs[i].v, 16'hABCD);
      check_output($sformatf("vec%0d_resync", i), 128'(resync_out), 128'(vecs[i].exp_resync));
      check_output($sformatf("vec%0d_overflow", i), 128'(overflow_out), 128'd0);
    end
    wait_drain("vec_drain", 50);

    $display("[TB] full frame, continuous, ready high");
    resync_base = resync_count;
    push_expected_words(0, TWORDS);
    drive_pixels(0, 7, 0);
    check_output("latency_before", 128'(write_axis_valid), 128'd0);
    drive_pixels(7, 1, 0);
    check_output("latency_valid", 128'(write_axis_valid), 128'd1);
    check_output("word0_data", write_axis_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    check_output("word0_tlast", 128'(write_axis_tlast), 128'd0);
    drive_pixels(8, TPIX - 8, 0);
    wait_drain("frame_drain", 100);
    check_output("frame_no_resync", 128'(resync_count - resync_base), 128'd0);

    $display("[TB] overflow with ready low");
    ready_mode = 0;
    push_expected_words(0, 2);
    push_terminator();
    drive_pixels(0, 16, 0);
    check_output("ovf_before", 128'(overflow_out), 128'd0);
    drive_pixels(16, 7, 0);
    check_output("ovf_resync_before", 128'(resync_out), 128'd0);
    drive_pixels(23, 1, 0);
    check_output("ovf_set", 128'(overflow_out), 128'd1);
    check_output("ovf_resync", 128'(resync_out), 128'd1);
    drive_pixels(24, 6, 0);
    check_output("ovf_valid_held", 128'(write_axis_valid), 128'd1);
    ready_mode = 1;
    wait_drain("ovf_drain", 20);
    check_output("ovf_sticky", 128'(overflow_out), 128'd1);

    $display("[TB] hcount jump on line 3");
    push_expected_words(0, 25);
    push_terminator();
    drive_pixels(0, 3 * TH + 14, 0);
    check_output("jump_before", 128'(resync_out), 128'd0);
    apply_stimulus(1'b1, 11'd15, 10'd3, 16'h1234);
    check_output("jump_resync", 128'(resync_out), 128'd1);
    drive_pixels(3 * TH + 16, 60, 0);
    wait_drain("jump_drain", 20);

    $display("[TB] reset mid-frame with two words buffered");
    push_expected_words(0, 60);
    drive_pixels(0, 484, 0);
    ready_mode = 0;
    drive_pixels(484, 16, 0);
    check_output("pre_reset_valid", 128'(write_axis_valid), 128'd1);
    check_output("pre_reset_queue", 128'(exp_q.size()), 128'd0);
    rst_in = 1'b1;
    apply_stimulus(1'b0, 11'd0, 10'd0, 16'd0);
    check_output("mid_rst_valid", 128'(write_axis_valid), 128'd0);
    check_output("mid_rst_overflow", 128'(overflow_out), 128'd0);
    rst_in = 1'b0;
    apply_stimulus(1'b0, 11'd0, 10'd0, 16'd0);

    $display("[TB] gapped pixels with random ready");
    ready_mode = 2;
    resync_base = resync_count;
    push_expected_words(0, TWORDS);
    drive_pixels(0, TPIX, 2);
    wait_drain("gap_drain", 2000);
    check_output("gap_no_resync", 128'(resync_count - resync_base), 128'd0);
    check_output("gap_no_overflow", 128'(overflow_out), 128'd0);

    ready_mode = 1;
    repeat (4) apply_stimulus(1'b0, 11'd0, 10'd0, 16'd0);
    check_output("final_queue_empty", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
